// File: rtl/float_sort3_stream_pkg.sv
// Shared types and helpers for the three-element float stream sorter.
package float_sort3_stream_pkg;

    localparam int FLEN  = 64;
    localparam int EXP_W = 11;
    localparam int MAN_W = 52;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CMP01A,
        ST_CMP12,
        ST_CMP01B,
        ST_EMIT
    } sort_state_e;

    // Quiet or signalling NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic is_nan(input logic [FLEN-1:0] v);
        return (v[FLEN-2 -: EXP_W] == {EXP_W{1'b1}}) && (v[MAN_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/float_sort3_stream_fle.sv
// FP64 a <= b comparator; err flags an unordered compare (either operand NaN).
module f_less_or_equal
    import float_sort3_stream_pkg::*;
(
    input  logic [FLEN-1:0] a_i,
    input  logic [FLEN-1:0] b_i,
    output logic            le_o,
    output logic            err_o
);

    // Sign-magnitude ordering; +0 and -0 compare equal, NaN reports err with le=0.
    always_comb begin
        le_o  = 1'b0;
        err_o = 1'b0;
        if (is_nan(a_i) || is_nan(b_i)) begin
            err_o = 1'b1;
        end else if ((a_i[FLEN-2:0] == '0) && (b_i[FLEN-2:0] == '0)) begin
            le_o = 1'b1;
        end else if (a_i[FLEN-1] != b_i[FLEN-1]) begin
            le_o = a_i[FLEN-1];
        end else if (a_i[FLEN-1]) begin
            le_o = (a_i[FLEN-2:0] >= b_i[FLEN-2:0]);
        end else begin
            le_o = (a_i[FLEN-2:0] <= b_i[FLEN-2:0]);
        end
    end

endmodule

// File: rtl/float_sort3_stream.sv
// Collects three FP64 operands, sorts them with a three-step stable
// compare/swap network sharing one comparator, then streams them out
// smallest first.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_LOAD   | accept operands into slot[cnt], cnt 0..2
// ST_CMP01A | compare/swap slot0, slot1
// ST_CMP12  | compare/swap slot1, slot2
// ST_CMP01B | compare/swap slot0, slot1 (final order)
// ST_EMIT   | present slot[cnt], advance cnt on each output transfer
module float_sort3_stream
    import float_sort3_stream_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            up_valid,
    input  logic [FLEN-1:0] up_data,
    output logic            up_ready,
    output logic            down_valid,
    output logic [FLEN-1:0] down_data,
    output logic            down_err,
    input  logic            down_ready
);

    sort_state_e     state_q;
    logic [1:0]      cnt_q;
    logic            err_q;
    logic            up_ready_q;
    logic            down_valid_q;
    logic [FLEN-1:0] slot0_q, slot1_q, slot2_q;

    logic [FLEN-1:0] cmp_a, cmp_b;
    logic            cmp_le, cmp_err;
    logic            in_cmp, hi_pair, swap;
    logic            up_fire, down_fire;

    assign up_fire   = up_valid & up_ready_q;
    assign down_fire = down_valid_q & down_ready;
    assign in_cmp    = (state_q == ST_CMP01A) || (state_q == ST_CMP12) || (state_q == ST_CMP01B);
    assign hi_pair   = (state_q == ST_CMP12);
    assign cmp_a     = hi_pair ? slot1_q : slot0_q;
    assign cmp_b     = hi_pair ? slot2_q : slot1_q;
    // Equal or unordered operands stay put, which keeps the sort stable.
    assign swap      = in_cmp & ~cmp_le & ~cmp_err;

    f_less_or_equal u_fle (
        .a_i   (cmp_a),
        .b_i   (cmp_b),
        .le_o  (cmp_le),
        .err_o (cmp_err)
    );

    // Sequencer: state, slot index, group error flag and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            cnt_q        <= 2'd0;
            err_q        <= 1'b0;
            up_ready_q   <= 1'b1;
            down_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (up_fire) begin
                        if (cnt_q == 2'd2) begin
                            cnt_q      <= 2'd0;
                            state_q    <= ST_CMP01A;
                            up_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                ST_CMP01A: begin
                    if (cmp_err) err_q <= 1'b1;
                    state_q <= ST_CMP12;
                end
                ST_CMP12: begin
                    if (cmp_err) err_q <= 1'b1;
                    state_q <= ST_CMP01B;
                end
                ST_CMP01B: begin
                    if (cmp_err) err_q <= 1'b1;
                    state_q      <= ST_EMIT;
                    down_valid_q <= 1'b1;
                end
                ST_EMIT: begin
                    if (down_fire) begin
                        if (cnt_q == 2'd2) begin
                            cnt_q        <= 2'd0;
                            err_q        <= 1'b0;
                            state_q      <= ST_LOAD;
                            down_valid_q <= 1'b0;
                            up_ready_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_LOAD;
                    cnt_q        <= 2'd0;
                    err_q        <= 1'b0;
                    up_ready_q   <= 1'b1;
                    down_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Slot storage: loaded during LOAD, permuted by the compare steps; no reset needed.
    always_ff @(posedge clk) begin
        if (up_fire) begin
            case (cnt_q)
                2'd0:    slot0_q <= up_data;
                2'd1:    slot1_q <= up_data;
                default: slot2_q <= up_data;
            endcase
        end else if (swap) begin
            if (hi_pair) begin
                slot1_q <= slot2_q;
                slot2_q <= slot1_q;
            end else begin
                slot0_q <= slot1_q;
                slot1_q <= slot0_q;
            end
        end
    end

    // Output select by emit index.
    always_comb begin
        case (cnt_q)
            2'd0:    down_data = slot0_q;
            2'd1:    down_data = slot1_q;
            default: down_data = slot2_q;
        endcase
    end

    assign up_ready   = up_ready_q;
    assign down_valid = down_valid_q;
    assign down_err   = err_q & down_valid_q;

endmodule
